inv_shift_rows_stage: RTL and testbench

- Elastic pipeline stage for the AES decryption datapath that applies InvShiftRows to a 128-bit state.
- Sits between the round-key-add/InvMixColumns output and the InvSubBytes stage of the inverse cipher.
- Provides a valid/ready handshake, a DEPTH-entry buffer, and a sideband tag (round index) carried in lockstep with each state.

---
 rtl/inv_shift_rows_stage.sv | 112 +++++++++++
 tb/tb_inv_shift_rows_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_shift_rows_stage.sv
// inv_shift_rows_stage: elastic AES-decrypt pipeline stage applying InvShiftRows.
// The transform is applied on write, so the buffer holds finished states and
// the outputs come straight from storage with no path from in_state.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   upstream state valid
//   in_ready   stage can accept (count != DEPTH)
//   in_state   128-bit column-major AES state
//   in_tag     sideband tag (round index)
//   out_valid  buffer non-empty (count != 0)
//   out_ready  downstream accepts
//   out_state  InvShiftRows result of the head entry
//   out_tag    tag of the head entry
//   count      current occupancy
//   flush      synchronous clear of all entries
module inv_shift_rows_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [127:0]             in_state,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [127:0]             out_state,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     flush
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [127:0]       mem_state [DEPTH];
  logic [TAG_W-1:0]   mem_tag   [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_nxt;
  logic               push;
  logic               pop;

  // Byte n sits at row n%4, column n/4; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return t;
  endfunction

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Occupancy update; flush wins over any concurrent push or pop.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Pointers, occupancy and registered handshake flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      count     <= count_nxt;
      in_ready  <= (count_nxt != CNT_W'(DEPTH));
      out_valid <= (count_nxt != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage is cleared on reset so the empty outputs read as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_state[i] <= '0;
        mem_tag[i]   <= '0;
      end
    end else if (push && !flush) begin
      mem_state[wr_ptr] <= inv_shift_rows(in_state);
      mem_tag[wr_ptr]   <= in_tag;
    end
  end

  assign out_state = mem_state[rd_ptr];
  assign out_tag   = mem_tag[rd_ptr];

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
module tb_inv_shift_rows_stage;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_tag;
  logic [1:0]   count;
  logic         flush;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [127:0] st;
    logic [3:0]   tag;
    logic [127:0] exp;
  } vec_t;

  typedef struct packed {
    logic [127:0] st;
    logic [3:0]   tag;
  } item_t;

  vec_t  vecs [5];
  item_t q [$];

  inv_shift_rows_stage #(.DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .out_tag(out_tag),
    .count(count), .flush(flush)
  );

  always #5 clk = ~clk;

  // Row r as a 32-bit word, column 0 in the most significant byte.
  function automatic logic [31:0] row_get(input logic [127:0] s, input int r);
    logic [31:0] w;
    for (int c = 0; c < 4; c++) w[31-8*c -: 8] = s[127-8*(r+4*c) -: 8];
    return w;
  endfunction

  function automatic logic [127:0] row_put(input logic [127:0] s, input int r, input logic [31:0] w);
    logic [127:0] o;
    o = s;
    for (int c = 0; c < 4; c++) o[127-8*(r+4*c) -: 8] = w[31-8*c -: 8];
    return o;
  endfunction

  // Inverse: each row word rotated right by r bytes.
  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    logic [127:0] o;
    logic [63:0]  d;
    o = s;
    for (int r = 1; r < 4; r++) begin
      d = {row_get(s, r), row_get(s, r)} >> (8*r);
      o = row_put(o, r, d[31:0]);
    end
    return o;
  endfunction

  // Forward ShiftRows: each row word rotated left by r bytes.
  function automatic logic [127:0] ref_fwd(input logic [127:0] s);
    logic [127:0] o;
    logic [63:0]  d;
    o = s;
    for (int r = 1; r < 4; r++) begin
      d = {row_get(s, r), row_get(s, r)} << (8*r);
      o = row_put(o, r, d[63:32]);
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] st0;
    logic [127:0] orig;
    logic [127:0] exp_st;
    logic [3:0]   got [$];
    logic         acc;
    logic         push_m;
    logic         pop_m;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 4'd3, 128'h000d0a0704010e0b0805020f0c090603};
    vecs[1] = '{128'h101112131415161718191a1b1c1d1e1f, 4'd7, 128'h101d1a1714111e1b1815121f1c191613};
    vecs[2] = '{128'h00aa000000bb000000cc000000dd0000, 4'd1, 128'h00dd000000aa000000bb000000cc0000};
    vecs[3] = '{128'h0, 4'd0, 128'h0};
    vecs[4] = '{{128{1'b1}}, 4'd15, {128{1'b1}}};

    reset = 1'b0; in_valid = 1'b0; in_state = '0; in_tag = '0;
    out_ready = 1'b0; flush = 1'b0;
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_count",     128'(count),     128'(0));
    chk("rst_out_state", out_state,       128'(0));
    chk("rst_out_tag",   128'(out_tag),   128'(0));
    reset = 1'b1;
    step();

    // Table vectors: single transfers, 1-cycle latency.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_state = vecs[i].st; in_tag = vecs[i].tag; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("vec_out_valid", 128'(out_valid), 128'(1));
      chk("vec_out_state", out_state, vecs[i].exp);
      chk("vec_out_tag",   128'(out_tag), 128'(vecs[i].tag));
      step();
      chk("vec_drained",   128'(count), 128'(0));
    end

    // Round trip through forward ShiftRows.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      orig = rnd128();
      in_state = ref_fwd(orig); in_tag = 4'(i);
      step();
      chk("rt_state", out_state, orig);
      chk("rt_count", 128'(count), 128'(1));
    end
    in_valid = 1'b0;
    step();

    // Backpressure: fill, hold tag 3 off, then drain in order.
    out_ready = 1'b0; in_valid = 1'b1;
    in_state = rnd128(); in_tag = 4'd1;
    step();
    in_state = rnd128(); in_tag = 4'd2;
    step();
    chk("bp_count_full", 128'(count), 128'(2));
    chk("bp_in_ready",   128'(in_ready), 128'(0));
    chk("bp_head_tag",   128'(out_tag), 128'(1));
    st0 = out_state;
    in_state = rnd128(); in_tag = 4'd3;
    step();
    step();
    chk("bp_count_hold", 128'(count), 128'(2));
    chk("bp_tag_stable", 128'(out_tag), 128'(1));
    chk("bp_state_stable", out_state, st0);
    chk("bp_valid_hold", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      acc = in_valid && in_ready;
      if (out_valid) got.push_back(out_tag);
      step();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_pop_count", 128'(got.size()), 128'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) chk("bp_pop_order", 128'(got[i]), 128'(i + 1));
      else                chk("bp_pop_missing", 128'(0), 128'(i + 1));
    end

    // Streaming with pointer wrap.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_state = rnd128(); in_tag = 4'(i);
      exp_st = ref_inv(in_state);
      step();
      chk("st_valid", 128'(out_valid), 128'(1));
      chk("st_tag",   128'(out_tag), 128'(i));
      chk("st_state", out_state, exp_st);
      chk("st_count", 128'(count), 128'(1));
    end
    in_valid = 1'b0;
    step();
    chk("st_drained", 128'(count), 128'(0));

    // Flush with a concurrent push.
    out_ready = 1'b0; in_valid = 1'b1;
    in_state = rnd128(); in_tag = 4'd5;
    step();
    in_state = rnd128(); in_tag = 4'd6;
    step();
    chk("fl_count_pre", 128'(count), 128'(2));
    flush = 1'b1; in_valid = 1'b1; in_tag = 4'd7;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count", 128'(count), 128'(0));
    chk("fl_out_valid", 128'(out_valid), 128'(0));
    chk("fl_in_ready", 128'(in_ready), 128'(1));
    step();
    chk("fl_push_dropped", 128'(count), 128'(0));

    // Async reset mid-operation.
    in_valid = 1'b1; in_state = rnd128(); in_tag = 4'd9;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("ar_count_pre", 128'(count), 128'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("ar_out_valid", 128'(out_valid), 128'(0));
    chk("ar_in_ready",  128'(in_ready),  128'(1));
    chk("ar_count",     128'(count),     128'(0));
    chk("ar_out_state", out_state,       128'(0));
    chk("ar_out_tag",   128'(out_tag),   128'(0));
    #2;
    reset = 1'b1;
    step();
    chk("ar_count_post", 128'(count), 128'(0));

    // Randomized traffic against a queue model.
    q.delete();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_state  = rnd128();
      in_tag    = 4'($urandom());
      #1;
      chk("rnd_count", 128'(count), 128'(q.size()));
      chk("rnd_out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("rnd_in_ready", 128'(in_ready), 128'(q.size() != DEPTH));
      if (q.size() != 0) begin
        chk("rnd_state", out_state, q[0].st);
        chk("rnd_tag", 128'(out_tag), 128'(q[0].tag));
      end
      push_m = in_valid && (q.size() < DEPTH);
      pop_m  = out_ready && (q.size() > 0);
      @(posedge clk);
      #1;
      if (flush) begin
        q.delete();
      end else begin
        if (pop_m)  void'(q.pop_front());
        if (push_m) q.push_back('{st: ref_inv(in_state), tag: in_tag});
      end
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
